seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
Consumes the rotation stage's `display_bcd`/`dp` output and drives a 4-digit common-anode 7-segment display by time-multiplexing the digits. It captures the input once per complete scan frame, so a rotation update never tears a frame. It also inserts an anti-ghosting guard interval per digit and optionally blanks leading zeros. It sits between the rotation module and the board pins.

Parameters:
CLK_HZ, 100_000_000, input clock frequency
REFRESH_HZ, 1000, per-digit slot rate; DIV = CLK_HZ/REFRESH_HZ, must be >= 2
GUARD, 1, cycles at the start of each slot with all anodes off; must satisfy 0 <= GUARD < DIV
DP_DIGIT, 2, digit index (0 = rightmost) whose decimal point `dp` lights
BLANK_LZ, 1, 1 = blank leading zeros

Ports:
clk100Mhz  in  1  system clock
rst  in  1  reset, asynchronous, active-high
display_bcd  in  16  four BCD nibbles; [3:0] = digit 0 (rightmost)
dp  in  1  decimal point request for DP_DIGIT
an  out  4  anode enables, active-low; an[i] = digit i
seg  out  7  cathodes, active-low, order {g,f,e,d,c,b,a}
dp_n  out  1  decimal point cathode, active-low
frame_done  out  1  one-cycle pulse after each snapshot capture

Behaviour:
- Single clock domain, clk100Mhz. `rst` asynchronously forces every register; it is released synchronously by design.
- Reset values: an=4'hF, seg=7'h7F, dp_n=1, frame_done=0, slot counter=0, digit index idx=0, snapshot={16'h0000, dp=0}.
- Slot counter:
  - cnt counts 0..DIV-1.
  - At cnt==DIV-1, cnt returns to 0 and idx advances 0->1->2->3->0.
  - One frame = 4*DIV cycles.
- Snapshot:
  - On the cycle where cnt==DIV-1 and idx==3, the snapshot registers load `display_bcd` and `dp`.
  - frame_done is registered high on the following cycle, for exactly 1 cycle.
  - Input changes at any other time have no effect until the next capture.
  - Frame 0 after reset displays the zero snapshot.
- Outputs are registered from the current (cnt, idx, snapshot): 1-cycle latency.
  - If cnt < GUARD: an=4'hF, seg=7'h7F, dp_n=1.
  - Otherwise: an = ~(1<<idx) unless the digit is blanked, in which case an=4'hF.
  - seg = decode(snapshot nibble idx).
  - dp_n = ~(snap_dp && idx==DP_DIGIT).
- Decode, active-low gfedcba:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - Nibbles A-F are invalid BCD and show dash 3F (segment g only).
- Leading-zero blanking (BLANK_LZ=1):
  - Digit i (i=3..1) is blanked when nibble i and all higher nibbles are 0.
  - Exception: when snap_dp=1, digits with i <= DP_DIGIT are never blanked.
  - Digit 0 is never blanked.
  - A blanked digit drives an bit 1, seg=7F, dp_n=1.
- Reset mid-frame: outputs go to reset values immediately (asynchronously). After release, scanning restarts at idx=0, cnt=0 with the zero snapshot.
- No handshake with the upstream rotation module: `display_bcd` is sampled only at the frame boundary, and the upstream must hold it stable for at least one cycle around the boundary. The upstream is already registered.

Decomposition:
- Package seg7_pkg: the 7-bit segment constants SEG_0..SEG_9, SEG_DASH (7'h3F), SEG_BLANK (7'h7F), and a 2-bit digit-index typedef.
- Sub-module bcd_to_seg7: purely combinational, nibble in -> 7-bit active-low pattern out, using the package constants.
- The top module holds the counters, snapshot, blanking logic and output registers.

Test Plan:
Run with CLK_HZ=1000, REFRESH_HZ=250 (DIV=4), GUARD=1.
1. Reset: rst=1 with inputs toggling -> an=F, seg=7F, dp_n=1, frame_done=0 continuously; asserting rst mid-slot forces the same values in the same cycle, with no clock edge needed.
2. display_bcd=16'h1234, dp=0, after the first frame_done:
   - Each slot shows 1 guard cycle of an=F, then 3 cycles of, in order: an=E/seg=19, an=D/seg=30, an=B/seg=24, an=7/seg=79.
   - frame_done repeats every 16 cycles.
3. display_bcd=16'h0567, dp=1 -> digit 3 blanked (an=F, seg=7F); digit 2 shows an=B, seg=12, dp_n=0; digits 1 and 0 show 02 and 78 with dp_n=1.
4. display_bcd=16'h0000, dp=0 -> digits 3..1 blanked; digit 0 shows an=E, seg=40. With BLANK_LZ=0, all four digits show 40.
5. Tearing check: change display_bcd from 1234 to 98A7 while idx=1 -> the remainder of that frame still shows 1234. The next frame shows 78, 3F (dash for A), 00, 10 on digits 0..3.
6. DIV boundary: set REFRESH_HZ so that DIV=2 with GUARD=1 -> each digit is lit for exactly 1 cycle per slot; the index wraps 3->0 without a skipped or repeated slot.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared segment patterns (active-low, {g,f,e,d,c,b,a}) and digit index type
// for the 4-digit 7-segment scan driver.
package seg7_pkg;

   typedef logic [1:0] digit_idx_t;

   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_DASH  = 7'h3F;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to active-low segment pattern; non-BCD codes show a dash.
module bcd_to_seg7
   import seg7_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   always_comb begin
      case (nibble)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 4-digit common-anode driver with per-frame snapshot,
// anti-ghosting guard cycles and optional leading-zero blanking.
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int CLK_HZ     = 100_000_000,
   parameter int REFRESH_HZ = 1000,
   parameter int GUARD      = 1,
   parameter int DP_DIGIT   = 2,
   parameter int BLANK_LZ   = 1
)
(
   input  logic        clk100Mhz,
   input  logic        rst,
   input  logic [15:0] display_bcd,
   input  logic        dp,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp_n,
   output logic        frame_done
);

   localparam int DIV = CLK_HZ / REFRESH_HZ;
   localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
   localparam digit_idx_t    DP_IDX  = digit_idx_t'(DP_DIGIT);

   logic [CW-1:0] cnt;
   digit_idx_t    idx;
   logic [15:0]   snap_bcd;
   logic          snap_dp;

   logic       slot_end;
   logic       frame_end;
   logic       in_guard;
   logic       blank;
   logic [3:0] nibble;
   logic [6:0] seg_dec;
   logic [3:0] lz;

   assign slot_end  = (cnt == CNT_MAX);
   assign frame_end = slot_end && (idx == 2'd3);
   assign in_guard  = (int'(cnt) < GUARD);
   assign nibble    = snap_bcd[4*idx +: 4];

   // lz[i]: nibble i and every higher nibble are zero; digit 0 is never blanked
   always_comb begin
      lz[3] = (snap_bcd[15:12] == 4'h0);
      lz[2] = lz[3] && (snap_bcd[11:8] == 4'h0);
      lz[1] = lz[2] && (snap_bcd[7:4] == 4'h0);
      lz[0] = 1'b0;
   end

   assign blank = (BLANK_LZ != 0) && lz[idx] && !(snap_dp && (idx <= DP_IDX));

   bcd_to_seg7 u_dec (
      .nibble (nibble),
      .seg    (seg_dec)
   );

   always_ff @(posedge clk100Mhz or posedge rst) begin
      if (rst) begin
         cnt        <= '0;
         idx        <= '0;
         snap_bcd   <= '0;
         snap_dp    <= 1'b0;
         an         <= 4'hF;
         seg        <= SEG_BLANK;
         dp_n       <= 1'b1;
         frame_done <= 1'b0;
      end else begin
         cnt <= slot_end ? '0 : cnt + CW'(1);
         if (slot_end)
            idx <= idx + 2'd1;
         // Capture only at the frame boundary so a frame never mixes two values
         if (frame_end) begin
            snap_bcd <= display_bcd;
            snap_dp  <= dp;
         end
         frame_done <= frame_end;
         if (in_guard || blank) begin
            an   <= 4'hF;
            seg  <= SEG_BLANK;
            dp_n <= 1'b1;
         end else begin
            an   <= ~(4'b0001 << idx);
            seg  <= seg_dec;
            dp_n <= ~(snap_dp && (idx == DP_IDX));
         end
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: three instances (DIV=4 blanking, DIV=4 no blanking,
// DIV=2) compared each cycle against a time-indexed behavioural model.
module tb_seg7_scan_driver;

   localparam int GUARD    = 1;
   localparam int DP_DIGIT = 2;
   localparam logic [12:0] RESET_VEC = {4'hF, 7'h7F, 1'b1, 1'b0};

   logic        clk100Mhz = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] display_bcd = 16'h0000;
   logic        dp = 1'b0;

   logic [3:0] an_a, an_b, an_c;
   logic [6:0] seg_a, seg_b, seg_c;
   logic       dp_n_a, dp_n_b, dp_n_c;
   logic       fd_a, fd_b, fd_c;
   logic [12:0] obs_a, obs_b, obs_c;
   logic [12:0] exp_a, exp_b, exp_c;

   int checks = 0;
   int errors = 0;
   int n = 0;
   logic [15:0] snap4, snap2;
   logic        sdp4, sdp2;
   logic [6:0]  seg_tab [16];

   assign obs_a = {an_a, seg_a, dp_n_a, fd_a};
   assign obs_b = {an_b, seg_b, dp_n_b, fd_b};
   assign obs_c = {an_c, seg_c, dp_n_c, fd_c};

   always #5 clk100Mhz = ~clk100Mhz;

   seg7_scan_driver #(.CLK_HZ(1000), .REFRESH_HZ(250), .GUARD(GUARD), .DP_DIGIT(DP_DIGIT), .BLANK_LZ(1)) dut_a (
      .clk100Mhz(clk100Mhz), .rst(rst), .display_bcd(display_bcd), .dp(dp),
      .an(an_a), .seg(seg_a), .dp_n(dp_n_a), .frame_done(fd_a));

   seg7_scan_driver #(.CLK_HZ(1000), .REFRESH_HZ(250), .GUARD(GUARD), .DP_DIGIT(DP_DIGIT), .BLANK_LZ(0)) dut_b (
      .clk100Mhz(clk100Mhz), .rst(rst), .display_bcd(display_bcd), .dp(dp),
      .an(an_b), .seg(seg_b), .dp_n(dp_n_b), .frame_done(fd_b));

   seg7_scan_driver #(.CLK_HZ(1000), .REFRESH_HZ(500), .GUARD(GUARD), .DP_DIGIT(DP_DIGIT), .BLANK_LZ(1)) dut_c (
      .clk100Mhz(clk100Mhz), .rst(rst), .display_bcd(display_bcd), .dp(dp),
      .an(an_c), .seg(seg_c), .dp_n(dp_n_c), .frame_done(fd_c));

   // Expected {an, seg, dp_n, frame_done} after the edge that ends cycle t
   function automatic logic [12:0] model(int t, int div, bit blz, logic [15:0] s, logic sdp);
      int   pos;
      int   d;
      logic fd;
      logic blanked;
      logic [3:0] nib;
      logic [3:0] an_e;
      pos = t % div;
      d   = (t / div) % 4;
      fd  = ((t % (4 * div)) == (4 * div - 1));
      if (pos < GUARD) return {4'hF, 7'h7F, 1'b1, fd};
      nib = s[4*d +: 4];
      blanked = blz && (d > 0) && ((s >> (4 * d)) == 16'h0) && !(sdp && (d <= DP_DIGIT));
      if (blanked) return {4'hF, 7'h7F, 1'b1, fd};
      an_e = 4'hF;
      an_e[d] = 1'b0;
      return {an_e, seg_tab[nib], ~(sdp && (d == DP_DIGIT)), fd};
   endfunction

   task automatic tick();
      @(posedge clk100Mhz);
      n++;
      exp_a = model(n - 1, 4, 1'b1, snap4, sdp4);
      exp_b = model(n - 1, 4, 1'b0, snap4, sdp4);
      exp_c = model(n - 1, 2, 1'b1, snap2, sdp2);
      if (n % 16 == 0) begin snap4 = display_bcd; sdp4 = dp; end
      if (n % 8 == 0)  begin snap2 = display_bcd; sdp2 = dp; end
      @(negedge clk100Mhz);
   endtask

   task automatic release_reset();
      rst = 1'b0;
      n = 0;
      snap4 = 16'h0; sdp4 = 1'b0;
      snap2 = 16'h0; sdp2 = 1'b0;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 6; i++) begin
         @(negedge clk100Mhz);
         display_bcd = 16'($urandom);
         dp = 1'($urandom);
         if (obs_a !== RESET_VEC) begin errors++; $display("FAIL reset_a got=%h exp=%h", obs_a, RESET_VEC); end
         if (obs_c !== RESET_VEC) begin errors++; $display("FAIL reset_c got=%h exp=%h", obs_c, RESET_VEC); end
         checks += 2;
      end
      display_bcd = 16'h1234;
      dp = 1'b0;
      release_reset();
      for (int i = 0; i < 10; i++) begin
         tick();
         if (obs_a !== exp_a) begin errors++; $display("FAIL post_reset_a n=%0d got=%h exp=%h", n, obs_a, exp_a); end
         if (obs_c !== exp_c) begin errors++; $display("FAIL post_reset_c n=%0d got=%h exp=%h", n, obs_c, exp_c); end
         checks += 2;
      end
      #2 rst = 1'b1;
      #1;
      if (obs_a !== RESET_VEC) begin errors++; $display("FAIL async_reset_a got=%h exp=%h", obs_a, RESET_VEC); end
      if (obs_b !== RESET_VEC) begin errors++; $display("FAIL async_reset_b got=%h exp=%h", obs_b, RESET_VEC); end
      if (obs_c !== RESET_VEC) begin errors++; $display("FAIL async_reset_c got=%h exp=%h", obs_c, RESET_VEC); end
      checks += 3;
      @(negedge clk100Mhz);
      if (obs_a !== RESET_VEC) begin errors++; $display("FAIL reset_hold_a got=%h exp=%h", obs_a, RESET_VEC); end
      checks++;
      release_reset();
   endtask

   task automatic run_checked(string name, int cycles);
      for (int i = 0; i < cycles; i++) begin
         tick();
         if (obs_a !== exp_a) begin errors++; $display("FAIL %s_a n=%0d got=%h exp=%h", name, n, obs_a, exp_a); end
         if (obs_b !== exp_b) begin errors++; $display("FAIL %s_b n=%0d got=%h exp=%h", name, n, obs_b, exp_b); end
         if (obs_c !== exp_c) begin errors++; $display("FAIL %s_c n=%0d got=%h exp=%h", name, n, obs_c, exp_c); end
         checks += 3;
      end
   endtask

   task automatic test_basic();
      display_bcd = 16'h1234; dp = 1'b0;
      run_checked("basic", 48);
   endtask

   task automatic test_dp_blank();
      display_bcd = 16'h0567; dp = 1'b1;
      run_checked("dp_blank", 48);
   endtask

   task automatic test_zero();
      display_bcd = 16'h0000; dp = 1'b0;
      run_checked("zero", 48);
   endtask

   task automatic test_tearing();
      int guard_cnt;
      display_bcd = 16'h1234; dp = 1'b0;
      run_checked("tear_pre", 32);
      guard_cnt = 0;
      while ((n % 16) != 5 && guard_cnt < 16) begin
         run_checked("tear_align", 1);
         guard_cnt++;
      end
      if (guard_cnt >= 16) begin errors++; $display("FAIL tear_align_timeout n=%0d", n); end
      checks++;
      display_bcd = 16'h98A7;
      run_checked("tear", 40);
   endtask

   task automatic test_random();
      int r;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            r = $urandom_range(0, 3);
            display_bcd = 16'($urandom) >> (4 * r);
            dp = 1'($urandom);
         end
         run_checked("random", 1);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 160; i++) begin
         if ((n % 8) == 7) begin
            display_bcd = 16'($urandom) >> (4 * $urandom_range(0, 3));
            dp = 1'($urandom);
         end
         run_checked("b2b", 1);
      end
   endtask

   initial begin
      seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
      snap4 = 16'h0; sdp4 = 1'b0;
      snap2 = 16'h0; sdp2 = 1'b0;
      test_reset();
      test_basic();
      test_dp_blank();
      test_zero();
      test_tearing();
      test_random();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
